pixel_seq_ctrl: RTL
===================

PIXEL_SEQ_CTRL -- requirements
Module: pixel_seq_ctrl

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of pixel channels converted per frame (1..8).
REQ-002 SHALL have parameter RST_CYC, default 2000, length of the pixel-reset phase and of the hold-settle phase in clk_in cycles.
REQ-003 SHALL have parameter T_SHORT, default 5000000, integration cycles when t_sel=0; T_LONG, default 50000000, when t_sel=1.
REQ-004 SHALL have parameter CW, default 32, width of the phase counter.
REQ-005 clk_in  in  1  sole clock; all logic on the rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 start  in  1  level; sampled in IDLE to begin a frame.
REQ-008 abort  in  1  level; forces STOP from any non-IDLE state.
REQ-009 t_sel  in  1  integration-time select; latched at frame start.
REQ-010 pix_rst_n  out  1  pixel reset, active low.
REQ-011 pix_hold_n  out  1  sample-and-hold, active low.
REQ-012 d_out  out  1  pixel drive strobe.
REQ-013 adc_start  out  1  one-cycle conversion request to the ADC driver.
REQ-014 adc_ch  out  3  channel address for the current conversion.
REQ-015 adc_done  in  1  one-cycle pulse; adc_data valid in the same cycle.
REQ-016 adc_data  in  12  conversion result.
REQ-017 res_valid/res_ready/res_ch[2:0]/res_data[11:0]  out/in/out/out  result stream, valid/ready handshake.
REQ-018 busy  out  1  high whenever state is not IDLE; frame_done  out  1  one-cycle pulse on completion.

Function
REQ-019 States SHALL be IDLE, RESET, INTEG, HOLD, CONV, WAIT, SEND, STOP.
REQ-020 IDLE->RESET when start=1; t_sel latched, counter cleared, channel index cleared.
REQ-021 RESET: pix_rst_n=0, d_out=1; leave to INTEG after exactly RST_CYC cycles.
REQ-022 INTEG: pix_rst_n=1, d_out=0; leave to HOLD after exactly T_SHORT or T_LONG cycles per latched t_sel.
REQ-023 HOLD: pix_hold_n=0, d_out=1; leave to CONV after RST_CYC cycles; pix_hold_n stays 0 through CONV/WAIT/SEND.
REQ-024 CONV: adc_start=1 for exactly one cycle with adc_ch=channel index, then WAIT.
REQ-025 WAIT: hold until adc_done; capture adc_data into res_data, res_ch=index, go SEND.
REQ-026 SEND: res_valid=1, data stable until res_valid&res_ready; then index+1 and CONV, or STOP if index==NUM_CH-1.
REQ-027 STOP: all pixel outputs to idle values, frame_done=1 for one cycle, then IDLE (or RESET, see REQ-033).
REQ-028 Counter SHALL clear on every state entry; comparisons use CW bits; no wrap within any phase.
REQ-029 abort in any non-IDLE state SHALL go to STOP next cycle, dropping any pending result (res_valid=0); frame_done still pulses.
REQ-030 adc_done outside WAIT SHALL be ignored; start while busy SHALL be ignored.

Reset
REQ-031 On reset=1: state IDLE; pix_rst_n=1, pix_hold_n=1, d_out=0, adc_start=0, adc_ch=0, res_valid=0, res_data=0, res_ch=0, busy=0, frame_done=0; counter and index 0. Reset mid-frame takes effect next edge with no frame_done.

Configuration
REQ-032 Macro PIXEL_SEQ_CONT_EN SHALL select continuous-frame mode.
REQ-033 With PIXEL_SEQ_CONT_EN: STOP->RESET if start still 1 and abort=0, re-latching t_sel; without it STOP->IDLE always and start must be re-sampled in IDLE.

Structure
REQ-034 State encoding enum and default timing constants SHALL live in shared package pixel_test_pkg.
REQ-035 Phase timer SHALL be sub-module phase_timer (clear, terminal-count compare, done flag).

Verification
REQ-036 RST_CYC=4, T_SHORT=10, t_sel=0, NUM_CH=2, start pulse -> pix_rst_n low 4 cycles, integ 10 cycles, hold-settle 4, two adc_start pulses with adc_ch 0 then 1, frame_done once.
REQ-037 adc_done after 7 cycles with data 0xABC, res_ready held low 5 cycles -> res_valid held, res_data=0xABC, res_ch=0 stable until accepted.
REQ-038 abort asserted in INTEG -> STOP next cycle, all outputs idle, frame_done pulse, no adc_start.
REQ-039 reset asserted in WAIT -> all outputs at reset values next edge, no frame_done, later adc_done ignored.
REQ-040 PIXEL_SEQ_CONT_EN defined, start held high -> back-to-back frames, RESET entered the cycle after STOP; undefined -> IDLE until start re-sampled.
REQ-041 t_sel toggled mid-frame -> current integration length unchanged; t_sel=1 next frame uses T_LONG.

Source files
------------

// File: rtl/pixel_test_pkg.sv
// Shared types and default timing constants for the pixel sequencer.
package pixel_test_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StReset,
      StInteg,
      StHold,
      StConv,
      StWait,
      StSend,
      StStop
   } state_e;

   localparam int unsigned DEF_NUM_CH  = 4;
   localparam int unsigned DEF_RST_CYC = 2000;
   localparam int unsigned DEF_T_SHORT = 5000000;
   localparam int unsigned DEF_T_LONG  = 50000000;
   localparam int unsigned DEF_CW      = 32;

   localparam int unsigned CH_W  = 3;
   localparam int unsigned ADC_W = 12;

endpackage

// File: rtl/pixel_seq_ctrl_if.sv
// ADC request/response and result-stream bundle for pixel_seq_ctrl.
interface pixel_seq_ctrl_if;
   import pixel_test_pkg::*;

   logic             adc_start;
   logic [CH_W-1:0]  adc_ch;
   logic             adc_done;
   logic [ADC_W-1:0] adc_data;
   logic             res_valid;
   logic             res_ready;
   logic [CH_W-1:0]  res_ch;
   logic [ADC_W-1:0] res_data;

   // Sequencer side
   modport master (
      output adc_start, adc_ch, res_valid, res_ch, res_data,
      input  adc_done, adc_data, res_ready
   );

   // ADC driver / result consumer side
   modport slave (
      input  adc_start, adc_ch, res_valid, res_ch, res_data,
      output adc_done, adc_data, res_ready
   );

endinterface

// File: rtl/pixel_seq_ctrl_phase_timer.sv
// Phase timer: counts cycles since the last clear and flags the final cycle of a phase.
module phase_timer #(
   parameter int unsigned CW = 32
) (
   input  logic          clk_in,
   input  logic          reset,
   input  logic          clear,
   input  logic [CW-1:0] terminal,
   output logic          done
);

   logic [CW-1:0] cnt_q;

   // Cycle counter; saturates so a long phase never wraps back to a short count
   always_ff @(posedge clk_in) begin
      if (reset || clear) begin
         cnt_q <= '0;
      end else if (cnt_q != '1) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   // Counter starts at 0 on phase entry, so the last of `terminal` cycles is terminal-1
   always_comb begin
      done = (cnt_q == terminal - 1'b1);
   end

endmodule

// File: rtl/pixel_seq_ctrl.sv
// Pixel frame sequencer: reset, integrate, sample-and-hold, then convert and stream
// NUM_CH channels. Define PIXEL_SEQ_CONT_EN for continuous-frame mode (STOP goes
// straight back to RESET while start stays high).
module pixel_seq_ctrl
   import pixel_test_pkg::*;
#(
   parameter int unsigned NUM_CH  = DEF_NUM_CH,
   parameter int unsigned RST_CYC = DEF_RST_CYC,
   parameter int unsigned T_SHORT = DEF_T_SHORT,
   parameter int unsigned T_LONG  = DEF_T_LONG,
   parameter int unsigned CW      = DEF_CW
) (
   input  logic             clk_in,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic             t_sel,
   output logic             pix_rst_n,
   output logic             pix_hold_n,
   output logic             d_out,
   output logic             busy,
   output logic             frame_done,
   pixel_seq_ctrl_if.master bus
);

   localparam logic [CW-1:0]   RST_C    = CW'(RST_CYC);
   localparam logic [CW-1:0]   SHORT_C  = CW'(T_SHORT);
   localparam logic [CW-1:0]   LONG_C   = CW'(T_LONG);
   localparam logic [CH_W-1:0] LAST_IDX = CH_W'(NUM_CH - 1);

   state_e           state_q, state_d;
   logic             t_sel_q, t_sel_d;
   logic [CH_W-1:0]  idx_q, idx_d;
   logic [CH_W-1:0]  res_ch_q, res_ch_d;
   logic [ADC_W-1:0] res_data_q, res_data_d;
   logic [CW-1:0]    terminal;
   logic             phase_done;

   // Every state change restarts the phase count
   phase_timer #(
      .CW (CW)
   ) u_timer (
      .clk_in   (clk_in),
      .reset    (reset),
      .clear    (state_d != state_q),
      .terminal (terminal),
      .done     (phase_done)
   );

   // Phase length for the current state; only timed states look at phase_done
   always_comb begin
      terminal = RST_C;
      if (state_q == StInteg) begin
         terminal = t_sel_q ? LONG_C : SHORT_C;
      end
   end

   // State and datapath registers
   always_ff @(posedge clk_in) begin
      if (reset) begin
         state_q    <= StIdle;
         t_sel_q    <= 1'b0;
         idx_q      <= '0;
         res_ch_q   <= '0;
         res_data_q <= '0;
      end else begin
         state_q    <= state_d;
         t_sel_q    <= t_sel_d;
         idx_q      <= idx_d;
         res_ch_q   <= res_ch_d;
         res_data_q <= res_data_d;
      end
   end

   // Next-state logic; abort overrides every busy state
   always_comb begin
      state_d    = state_q;
      t_sel_d    = t_sel_q;
      idx_d      = idx_q;
      res_ch_d   = res_ch_q;
      res_data_d = res_data_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StReset;
               t_sel_d = t_sel;
               idx_d   = '0;
            end
         end
         StReset: if (phase_done) state_d = StInteg;
         StInteg: if (phase_done) state_d = StHold;
         StHold:  if (phase_done) state_d = StConv;
         StConv:  state_d = StWait;
         StWait: begin
            if (bus.adc_done) begin
               res_data_d = bus.adc_data;
               res_ch_d   = idx_q;
               state_d    = StSend;
            end
         end
         StSend: begin
            if (bus.res_ready) begin
               if (idx_q == LAST_IDX) begin
                  state_d = StStop;
               end else begin
                  idx_d   = idx_q + 1'b1;
                  state_d = StConv;
               end
            end
         end
         StStop: begin
            idx_d = '0;
`ifdef PIXEL_SEQ_CONT_EN
            if (start && !abort) begin
               state_d = StReset;
               t_sel_d = t_sel;
            end else begin
               state_d = StIdle;
            end
`else
            state_d = StIdle;
`endif
         end
         default: state_d = StIdle;
      endcase
      if (abort && state_q != StIdle && state_q != StStop) begin
         state_d = StStop;
      end
   end

   // Moore outputs decoded from the current state
   always_comb begin
      pix_rst_n  = 1'b1;
      pix_hold_n = 1'b1;
      d_out      = 1'b0;
      unique case (state_q)
         StReset: begin
            pix_rst_n = 1'b0;
            d_out     = 1'b1;
         end
         StHold: begin
            pix_hold_n = 1'b0;
            d_out      = 1'b1;
         end
         StConv, StWait, StSend: pix_hold_n = 1'b0;
         default: ;
      endcase
      busy          = (state_q != StIdle);
      frame_done    = (state_q == StStop);
      bus.adc_start = (state_q == StConv);
      bus.adc_ch    = idx_q;
      bus.res_valid = (state_q == StSend);
      bus.res_ch    = res_ch_q;
      bus.res_data  = res_data_q;
   end

endmodule
